i2c_temp_responder: RTL

- I2C target (slave) that emulates the ADT7420 temperature sensor at the far end of the bus from i2c_master.
- Used in simulation and FPGA loopback to exercise i2c_master without the physical sensor.
- Oversamples SCL/SDA with the 100 MHz system clock, decodes START/STOP/address/data, ACKs its address and serves a small register map.
- Drives SDA open-drain only: pull low or release.

---
 rtl/i2c_pkg.sv | 46 ++++
 rtl/i2c_bus_sync.sv | 62 ++++++
 rtl/i2c_temp_responder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the ADT7420-style I2C temperature responder.
// Holds the FSM state enum, register addresses, ACK levels and the read-mux helper.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_WR_PTR    = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WR_DATA   = 4'd5,
        ST_DATA_ACK  = 4'd6,
        ST_RD_DATA   = 4'd7,
        ST_RD_ACK    = 4'd8,
        ST_WAIT_STOP = 4'd9
    } i2c_state_e;

    localparam logic [7:0] REG_TEMP_MSB = 8'h00;
    localparam logic [7:0] REG_TEMP_LSB = 8'h01;
    localparam logic [7:0] REG_STATUS   = 8'h02;
    localparam logic [7:0] REG_CONFIG   = 8'h03;
    localparam logic [7:0] REG_ID       = 8'h0B;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Read-side register map; unmapped addresses read as zero.
    function automatic logic [7:0] reg_read(
        input logic [7:0]  ptr,
        input logic [15:0] temp,
        input logic [7:0]  cfg,
        input logic [7:0]  dev_id
    );
        logic [7:0] data_s;
        case (ptr)
            REG_TEMP_MSB: data_s = temp[15:8];
            REG_TEMP_LSB: data_s = temp[7:0];
            REG_STATUS:   data_s = 8'h00;
            REG_CONFIG:   data_s = cfg;
            REG_ID:       data_s = dev_id;
            default:      data_s = 8'h00;
        endcase
        return data_s;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA into the clock domain and flags START, STOP and SCL edges.
// All event outputs are registered, giving three cycles from pin change to event.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_bit,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_meta_r, scl_sync_r, scl_hist_r;
    logic sda_meta_r, sda_sync_r, sda_hist_r;
    logic sda_bit_r, scl_rise_r, scl_fall_r, start_r, stop_r;

    // Two-flop synchronizers plus one history flop; reset to the idle-bus level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_hist_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_hist_r <= 1'b1;
        end else begin
            scl_meta_r <= scl_in;
            scl_sync_r <= scl_meta_r;
            scl_hist_r <= scl_sync_r;
            sda_meta_r <= sda_in;
            sda_sync_r <= sda_meta_r;
            sda_hist_r <= sda_sync_r;
        end
    end

    // Bus-condition decode; START/STOP need SCL high on both the current and prior cycle,
    // so an SDA change coincident with an SCL edge is treated as an ordinary data bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_bit_r  <= 1'b1;
            scl_rise_r <= 1'b0;
            scl_fall_r <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
        end else begin
            sda_bit_r  <= sda_sync_r;
            scl_rise_r <= scl_sync_r & ~scl_hist_r;
            scl_fall_r <= ~scl_sync_r & scl_hist_r;
            start_r    <= scl_hist_r & scl_sync_r & sda_hist_r & ~sda_sync_r;
            stop_r     <= scl_hist_r & scl_sync_r & ~sda_hist_r & sda_sync_r;
        end
    end

    assign sda_bit   = sda_bit_r;
    assign scl_rise  = scl_rise_r;
    assign scl_fall  = scl_fall_r;
    assign start_det = start_r;
    assign stop_det  = stop_r;

endmodule

// File: rtl/i2c_temp_responder.sv
// I2C target emulating an ADT7420: ACKs its address, accepts a pointer/config write
// and serves temperature, config and ID bytes, driving SDA open-drain only.
module i2c_temp_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h4B,
    parameter logic [7:0] DEV_ID   = 8'hCB
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_value,
    output logic [7:0]  config_reg,
    output logic        busy,
    output logic        addr_hit
);

    logic sda_bit_s, scl_rise_s, scl_fall_s, start_s, stop_s;

    i2c_bus_sync u_bus_sync (
        .clk       (clk_100MHz),
        .rst_n     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_bit   (sda_bit_s),
        .scl_rise  (scl_rise_s),
        .scl_fall  (scl_fall_s),
        .start_det (start_s),
        .stop_det  (stop_s)
    );

    i2c_state_e  state_r, state_n;
    logic [3:0]  bit_cnt_r, bit_cnt_n;
    logic [7:0]  shift_r, shift_n;
    logic [7:0]  ptr_r, ptr_n;
    logic [7:0]  rd_shift_r, rd_shift_n;
    logic [15:0] shadow_r, shadow_n;
    logic [7:0]  config_r, config_n;
    logic        rw_r, rw_n;
    logic        sda_oe_r, sda_oe_n;
    logic        busy_r, busy_n;
    logic        addr_hit_r, addr_hit_n;

    logic        cnt_full_s;
    logic [7:0]  shift_in_s;
    logic [7:0]  ptr_inc_s;
    logic [7:0]  rd_first_s;
    logic [7:0]  rd_next_s;

    assign cnt_full_s = (bit_cnt_r == 4'd8);
    assign shift_in_s = {shift_r[6:0], sda_bit_s};
    assign ptr_inc_s  = ptr_r + 8'd1;
    // First byte of a read comes straight from the live input, the same value the shadow captures.
    assign rd_first_s = reg_read(ptr_r, temp_value, config_r, DEV_ID);
    assign rd_next_s  = reg_read(ptr_inc_s, shadow_r, config_r, DEV_ID);

    // State and datapath registers.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'h00;
            ptr_r      <= 8'h00;
            rd_shift_r <= 8'h00;
            shadow_r   <= 16'h0000;
            config_r   <= 8'h00;
            rw_r       <= 1'b0;
            sda_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            addr_hit_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            bit_cnt_r  <= bit_cnt_n;
            shift_r    <= shift_n;
            ptr_r      <= ptr_n;
            rd_shift_r <= rd_shift_n;
            shadow_r   <= shadow_n;
            config_r   <= config_n;
            rw_r       <= rw_n;
            sda_oe_r   <= sda_oe_n;
            busy_r     <= busy_n;
            addr_hit_r <= addr_hit_n;
        end
    end

    // Next-state and datapath decode; STOP outranks START, both outrank bit traffic.
    always_comb begin
        state_n    = state_r;
        bit_cnt_n  = bit_cnt_r;
        shift_n    = shift_r;
        ptr_n      = ptr_r;
        rd_shift_n = rd_shift_r;
        shadow_n   = shadow_r;
        config_n   = config_r;
        rw_n       = rw_r;
        sda_oe_n   = sda_oe_r;
        busy_n     = busy_r;
        addr_hit_n = 1'b0;

        if (stop_s) begin
            state_n  = ST_IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else if (start_s) begin
            state_n   = ST_ADDR;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b1;
            bit_cnt_n = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sda_oe_n = 1'b0;
                end
                ST_ADDR: begin
                    if (scl_rise_s && !cnt_full_s) begin
                        shift_n   = shift_in_s;
                        bit_cnt_n = bit_cnt_r + 4'd1;
                    end else if (scl_fall_s && cnt_full_s) begin
                        if (shift_r[7:1] == DEV_ADDR) begin
                            sda_oe_n   = ~ACK;
                            addr_hit_n = 1'b1;
                            rw_n       = shift_r[0];
                            state_n    = ST_ADDR_ACK;
                        end else begin
                            sda_oe_n = 1'b0;
                            state_n  = ST_WAIT_STOP;
                        end
                    end else begin
                        state_n = ST_ADDR;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall_s) begin
                        if (rw_r) begin
                            // Release the ACK and put the first data bit on the bus together.
                            shadow_n   = temp_value;
                            sda_oe_n   = ~rd_first_s[7];
                            rd_shift_n = {rd_first_s[6:0], 1'b0};
                            bit_cnt_n  = 4'd1;
                            state_n    = ST_RD_DATA;
                        end else begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = 4'd0;
                            state_n   = ST_WR_PTR;
                        end
                    end else begin
                        state_n = ST_ADDR_ACK;
                    end
                end
                ST_WR_PTR: begin
                    if (scl_rise_s && !cnt_full_s) begin
                        shift_n   = shift_in_s;
                        bit_cnt_n = bit_cnt_r + 4'd1;
                    end else if (scl_fall_s && cnt_full_s) begin
                        ptr_n    = shift_r;
                        sda_oe_n = ~ACK;
                        state_n  = ST_PTR_ACK;
                    end else begin
                        state_n = ST_WR_PTR;
                    end
                end
                ST_PTR_ACK, ST_DATA_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = 4'd0;
                        state_n   = ST_WR_DATA;
                    end else begin
                        state_n = state_r;
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise_s && !cnt_full_s) begin
                        shift_n   = shift_in_s;
                        bit_cnt_n = bit_cnt_r + 4'd1;
                    end else if (scl_fall_s && cnt_full_s) begin
                        sda_oe_n = ~ACK;
                        if (ptr_r == REG_CONFIG) begin
                            config_n = shift_r;
                        end else begin
                            config_n = config_r;
                        end
                        ptr_n   = ptr_inc_s;
                        state_n = ST_DATA_ACK;
                    end else begin
                        state_n = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall_s) begin
                        if (cnt_full_s) begin
                            sda_oe_n = 1'b0;
                            state_n  = ST_RD_ACK;
                        end else begin
                            sda_oe_n   = ~rd_shift_r[7];
                            rd_shift_n = {rd_shift_r[6:0], 1'b0};
                            bit_cnt_n  = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        state_n = ST_RD_DATA;
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise_s) begin
                        if (sda_bit_s == NACK) begin
                            state_n = ST_WAIT_STOP;
                        end else begin
                            ptr_n      = ptr_inc_s;
                            rd_shift_n = rd_next_s;
                            bit_cnt_n  = 4'd0;
                            state_n    = ST_RD_DATA;
                        end
                    end else begin
                        state_n = ST_RD_ACK;
                    end
                end
                ST_WAIT_STOP: begin
                    sda_oe_n = 1'b0;
                end
                default: begin
                    sda_oe_n = 1'b0;
                    state_n  = ST_IDLE;
                end
            endcase
        end
    end

    assign sda_oe     = sda_oe_r;
    assign config_reg = config_r;
    assign busy       = busy_r;
    assign addr_hit   = addr_hit_r;

endmodule
